// File: rtl/seg7_scan.sv
// Multiplexed driver for a common-anode seven-segment display. It scans one digit per slot
// and uses a double-buffered data set that is committed only at frame boundaries.
module seg7_scan #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     en_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  data_we_i,
    output logic                  pending_o,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            C,
    output logic                  DP
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tc;
    logic                  commit;

    logic [4*DIGITS-1:0]   act_data, pen_data;
    logic [DIGITS-1:0]     act_en, pen_en;
    logic [DIGITS-1:0]     act_dp, pen_dp;
    logic                  pend;

    logic [3:0]            nib;
    logic [DIGITS-1:0]     an_nxt;
    logic [6:0]            c_nxt;
    logic                  dp_nxt;

    assign tc     = (presc == P_LAST);
    assign commit = tc && (idx == I_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tc ? '0 : presc + PW'(1);
            if (tc)
                idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
        end
    end

    // A write landing on the commit cycle bypasses the pending stage entirely.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_data <= '0;
            act_en   <= '0;
            act_dp   <= '0;
            pen_data <= '0;
            pen_en   <= '0;
            pen_dp   <= '0;
            pend     <= 1'b0;
        end else if (data_we_i && commit) begin
            act_data <= data_i;
            act_en   <= en_i;
            act_dp   <= dp_i;
            pend     <= 1'b0;
        end else if (data_we_i) begin
            pen_data <= data_i;
            pen_en   <= en_i;
            pen_dp   <= dp_i;
            pend     <= 1'b1;
        end else if (commit && pend) begin
            act_data <= pen_data;
            act_en   <= pen_en;
            act_dp   <= pen_dp;
            pend     <= 1'b0;
        end
    end

    assign pending_o = pend;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib    = act_data[{idx, 2'b00} +: 4];
        an_nxt = '1;
        c_nxt  = 7'h7F;
        dp_nxt = 1'b1;
        if (act_en[idx]) begin
            an_nxt = ~(DIGITS'(1) << idx);
            c_nxt  = hex_seg(nib);
            dp_nxt = ~act_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            AN <= '1;
            C  <= 7'h7F;
            DP <= 1'b1;
        end else begin
            AN <= an_nxt;
            C  <= c_nxt;
            DP <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (DIGITS=8, REFRESH_DIV=4). Directed and random writes are checked
// every cycle against a frame/slot model derived from the cycle count since reset release.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] data_i = '0;
    logic [7:0]  en_i = '0;
    logic [7:0]  dp_i = '0;
    logic        data_we_i = 1'b0;
    logic        pending_o;
    logic [7:0]  AN;
    logic [6:0]  C;
    logic        DP;

    int total = 0;
    int bad = 0;

    seg7_scan #(.DIGITS(8), .REFRESH_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .data_i(data_i), .en_i(en_i), .dp_i(dp_i),
        .data_we_i(data_we_i), .pending_o(pending_o), .AN(AN), .C(C), .DP(DP)
    );

    always #5 clk = ~clk;

    logic [6:0] hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: edges since reset release; 4 edges per slot, 32 per frame.
    int          n;
    logic [31:0] act_d, pen_d;
    logic [7:0]  act_e, pen_e, act_p, pen_p;
    logic        pend_m;
    logic [7:0]  e_an;
    logic [6:0]  e_c;
    logic        e_dp;

    task automatic model_reset();
        n = 0;
        act_d = '0; act_e = '0; act_p = '0;
        pen_d = '0; pen_e = '0; pen_p = '0;
        pend_m = 1'b0;
        e_an = 8'hFF; e_c = 7'h7F; e_dp = 1'b1;
    endtask

    task automatic check(input string tag);
        total++;
        assert (AN === e_an) else begin bad++; $error("FAIL %s AN got=%h exp=%h n=%0d", tag, AN, e_an, n); end
        total++;
        assert (C === e_c) else begin bad++; $error("FAIL %s C got=%h exp=%h n=%0d", tag, C, e_c, n); end
        total++;
        assert (DP === e_dp) else begin bad++; $error("FAIL %s DP got=%b exp=%b n=%0d", tag, DP, e_dp, n); end
        total++;
        assert (pending_o === pend_m) else begin bad++; $error("FAIL %s pending got=%b exp=%b n=%0d", tag, pending_o, pend_m, n); end
    endtask

    task automatic step(input string tag);
        int slot;
        bit is_commit;
        slot = (n / 4) % 8;
        is_commit = ((n % 32) == 31);
        if (act_e[slot]) begin
            e_an = ~(8'h01 << slot);
            e_c  = hex[act_d[slot*4 +: 4]];
            e_dp = ~act_p[slot];
        end else begin
            e_an = 8'hFF; e_c = 7'h7F; e_dp = 1'b1;
        end
        if (data_we_i && is_commit) begin
            act_d = data_i; act_e = en_i; act_p = dp_i; pend_m = 1'b0;
        end else if (data_we_i) begin
            pen_d = data_i; pen_e = en_i; pen_p = dp_i; pend_m = 1'b1;
        end else if (is_commit && pend_m) begin
            act_d = pen_d; act_e = pen_e; act_p = pen_p; pend_m = 1'b0;
        end
        n++;
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p, input string tag);
        data_i = d; en_i = e; dp_i = p; data_we_i = 1'b1;
        step(tag);
        data_we_i = 1'b0;
    endtask

    task automatic run_to_phase(input int ph, input string tag);
        for (int i = 0; i < 40 && (n % 32) != ph; i++) step(tag);
    endtask

    initial begin
        model_reset();
        #23;
        check("reset_hold");
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        run(100, "idle");

        write(32'h76543210, 8'hFF, 8'h00, "wr_all");
        run(70, "scan_all");

        write(32'hFFFFFFFF, 8'h05, 8'h04, "wr_sparse");
        run(70, "scan_sparse");

        run_to_phase(10, "align4");
        write($urandom, 8'hFF, $urandom_range(0, 255), "wr_a");
        run(3, "between_ab");
        write($urandom, 8'hFF, $urandom_range(0, 255), "wr_b");
        run(70, "scan_b");

        run_to_phase(20, "align5");
        write($urandom, 8'hFF, 8'h0F, "wr_y");
        run_to_phase(31, "wait_commit");
        write($urandom, 8'hFF, 8'hF0, "wr_x_commit");
        run(40, "scan_x");

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0)
                write($urandom, $urandom_range(0, 255), $urandom_range(0, 255), "rnd_wr");
            else
                step("rnd");
        end

        run_to_phase(5, "align6");
        write($urandom, 8'hFF, 8'hAA, "wr_before_rst");
        run(3, "pend_before_rst");
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(posedge clk); #1;
        check("rst_low");
        resetn = 1'b1;
        model_reset();
        run(50, "after_rst");

        write(32'h89ABCDEF, 8'hFF, 8'h81, "wr_post_rst");
        run(70, "scan_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
